// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU stage controller.
//   state_t  : controller state encoding, also exported on cur_state
//   STATE_W  : state width
//   WDOG_W   : stage watchdog counter width
//   is_stage : true for the five pipeline stage states (IF..WB)
package cpu_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int WDOG_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_TRAP = 3'd7
  } state_t;

  function automatic logic is_stage(input state_t s);
    return (s >= S_IF) && (s <= S_WB);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog counter.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clr    : clear the count (asserted on every controller state change)
//   inc    : count this cycle (stage valid held without its over)
//   expire : count has reached TIMEOUT-1
// Parameter TIMEOUT: legal range 2..255.
module stage_watchdog
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + WDOG_W'(1);
    end
  end

  assign expire = (cnt == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_stage_ctrl.sv
// Central sequencer for the multi-cycle CPU. Exactly one stage valid is
// high at a time; the sequencer advances on the current stage's over,
// retires jump/branch-without-link instructions straight from ID, halts at
// instruction boundaries and traps a stage that never completes.
//
// Optional build macro STAGE_PERF_CNT_EN adds retired-instruction and
// active-cycle counters; without it inst_cnt/cycle_cnt read 0.
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   halt_req                         : stop fetching at next boundary
//   IF/ID/EXE/MEM/WB_over            : per-stage completion handshakes
//   jbr_not_link                     : ID-stage jump/branch with no link
//   IF/ID/EXE/MEM/WB_valid           : registered one-hot stage enables
//   inst_retire                      : one-cycle retire pulse
//   halted, wdog_err                 : HALT state, sticky watchdog trap
//   cur_state                        : encoded state
//   inst_cnt, cycle_cnt              : performance counters
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | out of reset, decides between fetch and halt
// IF    | fetch stage valid
// ID    | decode stage valid
// EXE   | execute stage valid
// MEM   | memory stage valid
// WB    | writeback stage valid
// HALT  | stopped at a boundary until halt_req drops
// TRAP  | watchdog expired; only reset leaves
module multicycle_stage_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt_req,
  input  logic               IF_over,
  input  logic               ID_over,
  input  logic               EXE_over,
  input  logic               MEM_over,
  input  logic               WB_over,
  input  logic               jbr_not_link,
  output logic               IF_valid,
  output logic               ID_valid,
  output logic               EXE_valid,
  output logic               MEM_valid,
  output logic               WB_valid,
  output logic               inst_retire,
  output logic               halted,
  output logic               wdog_err,
  output logic [STATE_W-1:0] cur_state,
  output logic [CNT_W-1:0]   inst_cnt,
  output logic [CNT_W-1:0]   cycle_cnt
);

  state_t state, next_state;
  state_t boundary;
  logic   stage_over;
  logic   retire_d;
  logic   wd_expire;

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (next_state != state),
    .inc    (is_stage(state) && !stage_over),
    .expire (wd_expire)
  );

  // Only the over belonging to the current stage is ever looked at.
  always_comb begin
    stage_over = 1'b0;
    case (state)
      S_IF:    stage_over = IF_over;
      S_ID:    stage_over = ID_over;
      S_EXE:   stage_over = EXE_over;
      S_MEM:   stage_over = MEM_over;
      S_WB:    stage_over = WB_over;
      default: stage_over = 1'b0;
    endcase
  end

  assign boundary = halt_req ? S_HALT : S_IF;

  // An over in the terminal-count cycle takes priority over the trap.
  always_comb begin
    next_state = state;
    retire_d   = 1'b0;
    case (state)
      S_IDLE: next_state = boundary;
      S_HALT: next_state = boundary;
      S_IF:   if (stage_over) next_state = S_ID;
              else if (wd_expire) next_state = S_TRAP;
      S_ID: begin
        if (stage_over) begin
          if (jbr_not_link) begin
            retire_d   = 1'b1;
            next_state = boundary;
          end else begin
            next_state = S_EXE;
          end
        end else if (wd_expire) begin
          next_state = S_TRAP;
        end
      end
      S_EXE:  if (stage_over) next_state = S_MEM;
              else if (wd_expire) next_state = S_TRAP;
      S_MEM:  if (stage_over) next_state = S_WB;
              else if (wd_expire) next_state = S_TRAP;
      S_WB: begin
        if (stage_over) begin
          retire_d   = 1'b1;
          next_state = boundary;
        end else if (wd_expire) begin
          next_state = S_TRAP;
        end
      end
      S_TRAP: next_state = S_TRAP;
    endcase
  end

  // Outputs are decoded from next_state so they flop alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      IF_valid    <= 1'b0;
      ID_valid    <= 1'b0;
      EXE_valid   <= 1'b0;
      MEM_valid   <= 1'b0;
      WB_valid    <= 1'b0;
      inst_retire <= 1'b0;
      halted      <= 1'b0;
      wdog_err    <= 1'b0;
    end else begin
      state       <= next_state;
      IF_valid    <= (next_state == S_IF);
      ID_valid    <= (next_state == S_ID);
      EXE_valid   <= (next_state == S_EXE);
      MEM_valid   <= (next_state == S_MEM);
      WB_valid    <= (next_state == S_WB);
      inst_retire <= retire_d;
      halted      <= (next_state == S_HALT);
      wdog_err    <= (next_state == S_TRAP);
    end
  end

  assign cur_state = state;

`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] inst_q;
  logic [CNT_W-1:0] cycle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= '0;
      cycle_q <= '0;
    end else begin
      if (inst_retire) inst_q <= inst_q + CNT_W'(1);
      if (is_stage(state)) cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign inst_cnt  = inst_q;
  assign cycle_cnt = cycle_q;
`else
  assign inst_cnt  = '0;
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_stage_ctrl.sv
module tb_multicycle_stage_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst, halt_req, jbr_not_link;
  logic IF_over, ID_over, EXE_over, MEM_over, WB_over;
  logic IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
  logic inst_retire, halted, wdog_err;
  logic [2:0] cur_state;
  logic [CNT_W-1:0] inst_cnt, cycle_cnt;

  always #5 clk = ~clk;

  multicycle_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req),
    .IF_over(IF_over), .ID_over(ID_over), .EXE_over(EXE_over),
    .MEM_over(MEM_over), .WB_over(WB_over), .jbr_not_link(jbr_not_link),
    .IF_valid(IF_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
    .MEM_valid(MEM_valid), .WB_valid(WB_valid), .inst_retire(inst_retire),
    .halted(halted), .wdog_err(wdog_err), .cur_state(cur_state),
    .inst_cnt(inst_cnt), .cycle_cnt(cycle_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stage number 1..5 (IF..WB), 0 idle, 6 halt, 7 trap;
  // wait = cycles the current stage has been held without its over.
  int          m_stage = 0;
  int          m_wait  = 0;
  bit          m_retire = 1'b0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_cyc  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("IF_valid",    64'(IF_valid),    64'(m_stage == 1));
    chk("ID_valid",    64'(ID_valid),    64'(m_stage == 2));
    chk("EXE_valid",   64'(EXE_valid),   64'(m_stage == 3));
    chk("MEM_valid",   64'(MEM_valid),   64'(m_stage == 4));
    chk("WB_valid",    64'(WB_valid),    64'(m_stage == 5));
    chk("inst_retire", 64'(inst_retire), 64'(m_retire));
    chk("halted",      64'(halted),      64'(m_stage == 6));
    chk("wdog_err",    64'(wdog_err),    64'(m_stage == 7));
    chk("cur_state",   64'(cur_state),   64'(m_stage));
`ifdef STAGE_PERF_CNT_EN
    chk("inst_cnt",    64'(inst_cnt),    64'(m_inst));
    chk("cycle_cnt",   64'(cycle_cnt),   64'(m_cyc));
`else
    chk("inst_cnt",    64'(inst_cnt),    64'(0));
    chk("cycle_cnt",   64'(cycle_cnt),   64'(0));
`endif
  endtask

  // Apply one cycle of inputs, advance the model, check at the next negedge.
  task automatic tick(input logic r, input logic h, input logic [4:0] ov, input logic j);
    int  ns, nw;
    bit  in_stage, over, ret;
    rst = r; halt_req = h; jbr_not_link = j;
    {WB_over, MEM_over, EXE_over, ID_over, IF_over} = ov;
    in_stage = (m_stage >= 1) && (m_stage <= 5);
    over     = in_stage ? ov[m_stage-1] : 1'b0;
    ret      = 1'b0;
    ns       = m_stage;
    if (m_stage == 0 || m_stage == 6) begin
      ns = h ? 6 : 1;
    end else if (in_stage) begin
      if (over) begin
        if (m_stage == 5 || (m_stage == 2 && j)) begin
          ret = 1'b1;
          ns  = h ? 6 : 1;
        end else begin
          ns = m_stage + 1;
        end
      end else if (m_wait == TIMEOUT - 1) begin
        ns = 7;
      end
    end
    nw = (ns != m_stage) ? 0 : (in_stage && !over ? m_wait + 1 : m_wait);
    @(posedge clk);
    if (r) begin
      m_stage = 0; m_wait = 0; m_retire = 1'b0; m_inst = '0; m_cyc = '0;
    end else begin
      m_inst   = m_inst + (m_retire ? 32'd1 : 32'd0);
      m_cyc    = m_cyc + (in_stage ? 32'd1 : 32'd0);
      m_stage  = ns;
      m_wait   = nw;
      m_retire = ret;
    end
    @(negedge clk);
    check_all();
  endtask

  // Drive the over of whatever stage is active until the model reaches tgt.
  task automatic run_to(input int tgt, input logic h);
    bit reached = 1'b0;
    logic [4:0] ov;
    for (int n = 0; n < 40; n++) begin
      if (m_stage == tgt) begin
        reached = 1'b1;
        break;
      end
      ov = '0;
      if (m_stage >= 1 && m_stage <= 5) ov[m_stage-1] = 1'b1;
      tick(1'b0, h, ov, 1'b0);
    end
    chk("run_to_reached", 64'(reached), 64'(1));
  endtask

  initial begin
    int vcnt[5];
    int seq[$];
    int last_state;
    int ret_cyc;
    bit saw_exe;
    logic [4:0] ov;
    logic h;
    logic r;

    rst = 1'b1; halt_req = 1'b0; jbr_not_link = 1'b0;
    {WB_over, MEM_over, EXE_over, ID_over, IF_over} = '0;
    @(negedge clk);
    tick(1'b1, 1'b0, 5'b0, 1'b0);
    tick(1'b1, 1'b0, 5'b0, 1'b0);

    // Full instruction, each over one cycle after its valid rises.
    for (int k = 0; k < 5; k++) vcnt[k] = 0;
    last_state = 0;
    ret_cyc = -1;
    for (int c = 1; c <= 11; c++) begin
      ov = '0;
      if (m_stage >= 1 && m_stage <= 5 && m_wait == 1) ov[m_stage-1] = 1'b1;
      tick(1'b0, 1'b0, ov, 1'b0);
      if (int'(cur_state) != last_state) begin
        seq.push_back(int'(cur_state));
        last_state = int'(cur_state);
      end
      if (c <= 10) begin
        if (IF_valid)  vcnt[0]++;
        if (ID_valid)  vcnt[1]++;
        if (EXE_valid) vcnt[2]++;
        if (MEM_valid) vcnt[3]++;
        if (WB_valid)  vcnt[4]++;
      end
      if (inst_retire && ret_cyc < 0) ret_cyc = c;
    end
    chk("retire_cycle", 64'(ret_cyc), 64'(11));
    for (int k = 0; k < 5; k++) chk("valid_len", 64'(vcnt[k]), 64'(2));
    chk("seq_len", 64'(seq.size()), 64'(6));
    for (int k = 0; k < seq.size() && k < 6; k++)
      chk("seq_state", 64'(seq[k]), 64'((k % 5) + 1));

    // Jump/branch without link retires from ID.
    tick(1'b1, 1'b0, 5'b0, 1'b0);
    tick(1'b0, 1'b0, 5'b0, 1'b0);
    tick(1'b0, 1'b0, 5'b00001, 1'b0);
    saw_exe = 1'b0;
    tick(1'b0, 1'b0, 5'b00010, 1'b1);
    saw_exe |= EXE_valid;
    chk("jbr_if_valid", 64'(IF_valid), 64'(1));
    chk("jbr_retire", 64'(inst_retire), 64'(1));
    tick(1'b0, 1'b0, 5'b0, 1'b0);
    saw_exe |= EXE_valid;
    chk("jbr_no_exe", 64'(saw_exe), 64'(0));
`ifdef STAGE_PERF_CNT_EN
    chk("jbr_inst_cnt", 64'(inst_cnt), 64'(1));
`endif

    // halt_req raised in EXE takes effect only at the boundary.
    run_to(3, 1'b0);
    tick(1'b0, 1'b1, 5'b00100, 1'b0);
    chk("halt_mem", 64'(cur_state), 64'(4));
    tick(1'b0, 1'b1, 5'b01000, 1'b0);
    tick(1'b0, 1'b1, 5'b10000, 1'b0);
    chk("halt_halted", 64'(halted), 64'(1));
    chk("halt_valids", 64'({IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid}), 64'(0));
    tick(1'b0, 1'b1, 5'b0, 1'b0);
    tick(1'b0, 1'b0, 5'b0, 1'b0);
    chk("unhalt_if", 64'(IF_valid), 64'(1));

    // Watchdog: MEM_over withheld.
    run_to(4, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b0, 1'b0, 5'b0, 1'b0);
    chk("wdog_last_mem", 64'(cur_state), 64'(4));
    tick(1'b0, 1'b0, 5'b0, 1'b0);
    chk("wdog_trap", 64'(cur_state), 64'(7));
    chk("wdog_err", 64'(wdog_err), 64'(1));
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 5'b01000, 1'b0);
    chk("wdog_late_over", 64'(cur_state), 64'(7));
    tick(1'b1, 1'b0, 5'b0, 1'b0);
    chk("wdog_rst_state", 64'(cur_state), 64'(0));
    chk("wdog_rst_err", 64'(wdog_err), 64'(0));
    tick(1'b0, 1'b0, 5'b0, 1'b0);

    // Stray EXE_over in ID.
    tick(1'b0, 1'b0, 5'b00001, 1'b0);
    tick(1'b0, 1'b0, 5'b00100, 1'b0);
    chk("stray_state", 64'(cur_state), 64'(2));
    chk("stray_err", 64'(wdog_err), 64'(0));
    tick(1'b0, 1'b0, 5'b00010, 1'b0);
    chk("stray_advance", 64'(cur_state), 64'(3));

    // Reset in the middle of WB.
    run_to(5, 1'b0);
    tick(1'b1, 1'b0, 5'b0, 1'b0);
    chk("rst_wb_state", 64'(cur_state), 64'(0));
    chk("rst_wb_outs", 64'({IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
                            inst_retire, halted, wdog_err}), 64'(0));
    chk("rst_wb_cnts", 64'(inst_cnt | cycle_cnt), 64'(0));

    // Random traffic including stray overs, halts, traps and resets.
    h = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 199) == 0) || (m_stage == 7 && $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) h = ~h;
      for (int k = 0; k < 5; k++) ov[k] = ($urandom_range(0, 2) == 0);
      tick(r, h, ov, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
